// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator arithmetic units.
//   WIDTH      : operand/result width of the arithmetic units (40)
//   CNT_W      : width of the per-bit step counter (covers 0..WIDTH-1)
//   CNT_LAST   : counter value on the final CALC edge
//   sq_state_t : squarer control states
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam int WIDTH = 40;
  localparam int CNT_W = 6;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } sq_state_t;

endpackage : calc_pkg

// File: rtl/cuadrado_secuencial_if.sv
// -----------------------------------------------------------------------------
// cuadrado_secuencial_if
// START/DONE/COUT handshake bundle shared by the calculator arithmetic units.
// Signal suffixes are from the arithmetic unit's point of view.
//   start_i : request, sampled only while the unit is idle
//   in_i    : unsigned operand, captured on the accepting edge
//   out_o   : low WIDTH bits of the result
//   cout_o  : result overflowed WIDTH bits
//   done_o  : one-cycle pulse, out_o/cout_o are new
//   busy_o  : operation in progress
// Modports: master = requester (op-select logic), slave = arithmetic unit.
// -----------------------------------------------------------------------------
interface cuadrado_secuencial_if;

  logic                       start_i;
  logic [calc_pkg::WIDTH-1:0] in_i;
  logic [calc_pkg::WIDTH-1:0] out_o;
  logic                       cout_o;
  logic                       done_o;
  logic                       busy_o;

  modport master (
    output start_i,
    output in_i,
    input  out_o,
    input  cout_o,
    input  done_o,
    input  busy_o
  );

  modport slave (
    input  start_i,
    input  in_i,
    output out_o,
    output cout_o,
    output done_o,
    output busy_o
  );

endinterface : cuadrado_secuencial_if

// File: rtl/cuadrado_fsm.sv
// -----------------------------------------------------------------------------
// cuadrado_fsm
// Control for the sequential squarer: owns the state and the bit counter and
// sequences exactly WIDTH shift-and-add steps per accepted request.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting; START loads the datapath
//   CALC  | one shift-and-add step per edge, WIDTH edges total
//   FIN   | result is registered, DONE raised, back to IDLE
//
// Ports:
//   clk_i, rst_i : clock, async active-high reset
//   start_i      : request (only looked at in IDLE)
//   load_o       : datapath load strobe (accepting edge)
//   step_o       : datapath shift-and-add strobe
//   finish_o     : datapath result-capture strobe
//   busy_o       : registered, high from accepting edge until DONE
//   done_o       : registered one-cycle completion pulse
// -----------------------------------------------------------------------------
module cuadrado_fsm
  import calc_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic load_o,
  output logic step_o,
  output logic finish_o,
  output logic busy_o,
  output logic done_o
);

  sq_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  // Strobes describe what the datapath does on the coming edge, so they are
  // decoded from the current state rather than registered.
  always_comb begin
    load_o   = (state_q == IDLE) && start_i;
    step_o   = (state_q == CALC);
    finish_o = (state_q == FIN);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          // No early exit even when the multiplier runs out of ones: the
          // latency must stay fixed for the op-select sequencing.
          if (cnt_q == CNT_LAST) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule : cuadrado_fsm

// File: rtl/cuadrado_secuencial.sv
// -----------------------------------------------------------------------------
// cuadrado_secuencial
// Sequential unsigned squarer: OUT = low WIDTH bits of IN*IN, COUT flags any
// nonzero upper product bit. One shift-and-add step per clock; fixed latency
// of WIDTH+1 edges from the accepting edge to DONE.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : async active-high reset, clears all state and outputs
//   bus   : handshake bundle (slave side), see cuadrado_secuencial_if
// -----------------------------------------------------------------------------
module cuadrado_secuencial
  import calc_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  cuadrado_secuencial_if.slave bus
);

  localparam int PW = 2 * WIDTH;

  logic load, step, finish;
  logic busy, done;

  logic [PW-1:0]    a_q,    a_d;
  logic [WIDTH-1:0] b_q,    b_d;
  logic [PW-1:0]    acc_q,  acc_d;
  logic [WIDTH-1:0] out_q,  out_d;
  logic             cout_q, cout_d;

  cuadrado_fsm u_fsm (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (bus.start_i),
    .load_o   (load),
    .step_o   (step),
    .finish_o (finish),
    .busy_o   (busy),
    .done_o   (done)
  );

  // A is the multiplicand shifted left each step, B the multiplier shifted
  // right; the product of two WIDTH-bit values always fits in PW bits, so the
  // accumulator add never wraps.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    out_d  = out_q;
    cout_d = cout_q;
    if (load) begin
      a_d   = {{WIDTH{1'b0}}, bus.in_i};
      b_d   = bus.in_i;
      acc_d = '0;
    end else if (step) begin
      if (b_q[0]) begin
        acc_d = acc_q + a_q;
      end
      a_d = a_q << 1;
      b_d = b_q >> 1;
    end
    if (finish) begin
      out_d  = acc_q[WIDTH-1:0];
      cout_d = |acc_q[PW-1:WIDTH];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      out_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      out_q  <= out_d;
      cout_q <= cout_d;
    end
  end

  assign bus.out_o  = out_q;
  assign bus.cout_o = cout_q;
  assign bus.done_o = done;
  assign bus.busy_o = busy;

endmodule : cuadrado_secuencial

// File: tb/tb_cuadrado_secuencial.sv
module tb_cuadrado_secuencial;
  import calc_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  cuadrado_secuencial_if bus ();

  cuadrado_secuencial dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [WIDTH-1:0] op;
    logic [WIDTH-1:0] exp_out;
    logic             exp_cout;
  } vec_t;

  vec_t tbl[7];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Counts edges after E0 until DONE is seen (0 if not seen within budget).
  task automatic wait_done(input int budget, output int edges);
    int n;
    n = 0;
    edges = 0;
    while (edges == 0 && n < budget) begin
      @(posedge clk_i); #1;
      n++;
      if (bus.done_o) edges = n;
    end
  endtask

  task automatic run_op(input string nm, input logic [WIDTH-1:0] op,
                        input logic [WIDTH-1:0] exp_out, input logic exp_cout);
    int e;
    @(negedge clk_i);
    bus.start_i = 1'b1;
    bus.in_i    = op;
    @(posedge clk_i); #1;
    chk({nm, " busy_at_e0"}, 80'(bus.busy_o), 80'(1));
    bus.start_i = 1'b0;
    bus.in_i    = ~op;
    wait_done(60, e);
    chk({nm, " latency"}, 80'(e), 80'(41));
    chk({nm, " out"}, 80'(bus.out_o), 80'(exp_out));
    chk({nm, " cout"}, 80'(bus.cout_o), 80'(exp_cout));
    chk({nm, " busy_at_done"}, 80'(bus.busy_o), 80'(0));
    @(posedge clk_i); #1;
    chk({nm, " done_pulse_end"}, 80'(bus.done_o), 80'(0));
  endtask

  initial begin
    int e;
    int seen;

    tbl[0] = '{40'd0,          40'd0,          1'b0};
    tbl[1] = '{40'd3,          40'd9,          1'b0};
    tbl[2] = '{40'h00000FFFFF, 40'hFFFFE00001, 1'b0};
    tbl[3] = '{40'h0000100000, 40'h0000000000, 1'b1};
    tbl[4] = '{40'hFFFFFFFFFF, 40'h0000000001, 1'b1};
    tbl[5] = '{40'd1,          40'd1,          1'b0};
    tbl[6] = '{40'd123456,     40'd15241383936, 1'b0};

    bus.start_i = 1'b0;
    bus.in_i    = '0;

    #12;
    chk("rst out", 80'(bus.out_o), 80'(0));
    chk("rst cout", 80'(bus.cout_o), 80'(0));
    chk("rst done", 80'(bus.done_o), 80'(0));
    chk("rst busy", 80'(bus.busy_o), 80'(0));
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].exp_out, tbl[i].exp_cout);
    end

    // Busy-time START is ignored; then START held gives back-to-back results.
    @(negedge clk_i);
    bus.start_i = 1'b1;
    bus.in_i    = 40'd11;
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    repeat (9) begin @(posedge clk_i); #1; end
    bus.start_i = 1'b1;
    bus.in_i    = 40'd7;
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    chk("ignore busy_still", 80'(bus.busy_o), 80'(1));
    wait_done(50, e);
    chk("ignore latency", 80'(e + 10), 80'(41));
    chk("ignore out", 80'(bus.out_o), 80'(121));
    bus.start_i = 1'b1;
    bus.in_i    = 40'd5;
    wait_done(60, e);
    chk("b2b spacing", 80'(e), 80'(42));
    chk("b2b out", 80'(bus.out_o), 80'(25));
    chk("b2b cout", 80'(bus.cout_o), 80'(0));
    bus.start_i = 1'b0;
    repeat (45) begin @(posedge clk_i); #1; end
    chk("b2b idle", 80'(bus.busy_o), 80'(0));

    // Reset in the middle of CALC.
    @(negedge clk_i);
    bus.start_i = 1'b1;
    bus.in_i    = 40'd1000;
    @(posedge clk_i); #1;
    bus.start_i = 1'b0;
    repeat (20) begin @(posedge clk_i); #1; end
    rst_i = 1'b1;
    #1;
    chk("midrst out", 80'(bus.out_o), 80'(0));
    chk("midrst cout", 80'(bus.cout_o), 80'(0));
    chk("midrst busy", 80'(bus.busy_o), 80'(0));
    chk("midrst done", 80'(bus.done_o), 80'(0));
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    seen = 0;
    repeat (50) begin
      @(posedge clk_i); #1;
      if (bus.done_o) seen = 1;
    end
    chk("midrst no_done", 80'(seen), 80'(0));
    run_op("after_rst", 40'd1000, 40'd1000000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_cuadrado_secuencial
